// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared types and helpers for the data_ram access unit.
//   mem_size_t  : request access size encoding (3 is illegal)
//   mau_state_t : access FSM state encoding
//   is_misaligned(size, addr_lo) : 1 when the request cannot be executed
//     because of its size/alignment (illegal size counts as an error too)
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } mau_state_t;

  // Size 3 has no meaning, so it is folded into the same error path as a
  // misaligned halfword/word.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// mem_lane_unit
// Combinational lane steering for the data_ram access unit.
//   addr_lo   in  2   byte offset inside the word
//   size      in  2   access size (mem_size_t encoding)
//   is_signed in  1   sign-extend sub-word load data
//   ram_word  in  32  word read from the RAM
//   wdata     in  32  store data, right-aligned
//   load_data out 32  extracted and extended load result
//   merged    out 32  ram_word with the store data inserted at its lane(s)
// Lanes are little-endian: byte n is bits [8n+7:8n], the upper half is [31:16].
module mem_lane_unit
  import mem_access_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] ram_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;

  always_comb begin
    // Bring the addressed lane down to bit 0 so extraction is size-only.
    shifted   = ram_word >> {addr_lo, 3'b000};
    load_data = ram_word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
        merged    = ram_word;
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
        merged    = ram_word;
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data = ram_word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Initiator for the word-wide data_ram. Turns CPU byte/half/word loads and
// stores into RAM cycles; sub-word stores are read-modify-write because the
// RAM has a single write enable and no byte enables.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request channel
//   req_we, req_size, req_signed, req_addr, req_wdata   request payload
//   rsp_valid/rsp_ready          response channel
//   rsp_rdata, rsp_err           response payload
//   ram_a, ram_d, ram_we, ram_spo  data_ram port (asynchronous read)
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. The producer holds valid and payload stable until that edge; the
// response payload stays stable while rsp_valid=1 and rsp_ready=0.
// Optional build macro MEM_ACCESS_BOUNDS_CHECK_EN: a request with any nonzero
// address bit above the RAM range is rejected with rsp_err instead of wrapping.
// The FSM state is visible as the internal signal 'state'.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_d,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_spo
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("mem_access_unit: DATA_WIDTH must be 32");
  end

  mau_state_t  state;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_addr_lo;
  logic [31:0] lat_wdata;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        req_err;
  logic        accept;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  logic range_err;
  assign range_err = |req_addr[31:ADDR_WIDTH+2];
`else
  // Upper address bits are intentionally dropped so accesses wrap.
  logic unused_upper_addr;
  assign unused_upper_addr = ^req_addr[31:ADDR_WIDTH+2];
  logic range_err;
  assign range_err = 1'b0;
`endif

  assign req_err   = is_misaligned(req_size, req_addr[1:0]) | range_err;
  assign accept    = req_valid && req_ready;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  // Decoded straight from the state register so the RAM never sees a glitch
  // and ram_spo is never sampled in a cycle where ram_we is high.
  assign ram_we    = (state == WRITE);

  mem_lane_unit u_lane (
    .addr_lo   (lat_addr_lo),
    .size      (lat_size),
    .is_signed (lat_signed),
    .ram_word  (ram_spo[31:0]),
    .wdata     (lat_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_size    <= 2'd0;
      lat_signed  <= 1'b0;
      lat_addr_lo <= 2'd0;
      lat_wdata   <= '0;
      ram_a       <= '0;
      ram_d       <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we      <= req_we;
            lat_size    <= req_size;
            lat_signed  <= req_signed;
            lat_addr_lo <= req_addr[1:0];
            lat_wdata   <= req_wdata;
            ram_a       <= req_addr[ADDR_WIDTH+1:2];
            if (req_err) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end else if (req_we && (req_size == SZ_WORD)) begin
              // Full-word store needs no read; write straight away.
              ram_d <= req_wdata;
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (lat_we) begin
            ram_d <= merged;
            state <= WRITE;
          end else begin
            rsp_rdata <= load_data;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end
        end
        WRITE: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int AW = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_signed = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_d;
  logic          ram_we;
  logic [31:0]   ram_spo;

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo)
  );

  // RAM model: write on posedge, asynchronous read; garbage while writing.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;
  assign ram_spo = ram_we ? 32'hBADC0DE5 : mem[ram_a];

  // write-pulse monitor
  int          we_cnt = 0;
  logic [31:0] last_wd = '0;
  always @(negedge clk) if (ram_we) begin
    we_cnt  <= we_cnt + 1;
    last_wd <= ram_d;
  end

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // driver: one full request/response with rsp_ready held high
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int wes);
    int start_we;
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    start_we = we_cnt;
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk);
    wes = we_cnt - start_we;
  endtask

  task automatic run_check(input string tag, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_lat, input int exp_wes);
    logic [31:0] rd;
    logic        er;
    int          lt;
    int          ws;
    exp_q.push_back(exp_rdata);
    do_req(we, size, sgn, addr, wdata, rd, er, lt, ws);
    check({tag, "_rdata"}, rd, exp_q.pop_front());
    check({tag, "_err"}, 32'(er), 32'(exp_err));
    check({tag, "_lat"}, 32'(lt), 32'(exp_lat));
    check({tag, "_we_pulses"}, 32'(ws), 32'(exp_wes));
  endtask

  initial begin
    int start_we;
    int guard;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_ram_d", ram_d, 32'd0);
    rst = 1'b0;

    // word store then word load
    run_check("st_w_100", 1, 2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2, 1);
    check("ram64_deadbeef", mem[64], 32'hDEADBEEF);
    run_check("ld_w_100", 0, 2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 0);

    // byte store read-modify-write
    run_check("st_w_11223344", 1, 2, 0, 32'h100, 32'h11223344, 32'h0, 0, 2, 1);
    run_check("st_b_102", 1, 0, 0, 32'h102, 32'h000000AA, 32'h0, 0, 3, 1);
    check("rmw_ram_d", last_wd, 32'h11AA3344);
    check("ram64_rmw", mem[64], 32'h11AA3344);

    // sub-word loads with extension
    run_check("st_w_80ff7f01", 1, 2, 0, 32'h100, 32'h80FF7F01, 32'h0, 0, 2, 1);
    run_check("ld_sb_101", 0, 0, 1, 32'h101, 32'h0, 32'h0000007F, 0, 2, 0);
    run_check("ld_sb_102", 0, 0, 1, 32'h102, 32'h0, 32'hFFFFFFFF, 0, 2, 0);
    run_check("ld_sh_102", 0, 1, 1, 32'h102, 32'h0, 32'hFFFF80FF, 0, 2, 0);
    run_check("ld_uh_102", 0, 1, 0, 32'h102, 32'h0, 32'h000080FF, 0, 2, 0);
    run_check("ld_ub_103", 0, 0, 0, 32'h103, 32'h0, 32'h00000080, 0, 2, 0);
    run_check("ld_sb_103", 0, 0, 1, 32'h103, 32'h0, 32'hFFFFFF80, 0, 2, 0);
    run_check("ld_sh_100", 0, 1, 1, 32'h100, 32'h0, 32'h00007F01, 0, 2, 0);

    // error paths
    run_check("err_sh_101", 1, 1, 0, 32'h101, 32'h0000FFFF, 32'h0, 1, 1, 0);
    run_check("err_lw_102", 0, 2, 0, 32'h102, 32'h0, 32'h0, 1, 1, 0);
    run_check("err_size3", 0, 3, 0, 32'h100, 32'h0, 32'h0, 1, 1, 0);
    run_check("err_sw_103", 1, 2, 0, 32'h103, 32'h12345678, 32'h0, 1, 1, 0);
    check("ram64_unchanged", mem[64], 32'h80FF7F01);

    // half store to upper half
    run_check("st_h_102", 1, 1, 0, 32'h102, 32'hFFFF1234, 32'h0, 0, 3, 1);
    check("rmw_half_ram_d", last_wd, 32'h12347F01);

    // back-pressure on the response channel
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h100; req_wdata = '0;
    @(posedge clk);
    #1;
    req_size = 2'd1; req_addr = 32'h102;  // second request, held pending
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    check("hold_rsp_arrives", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'h12347F01);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    guard = 0;
    while (guard < 20) begin
      @(negedge clk);
      guard++;
      if (rsp_valid) break;
    end
    check("second_lat", 32'(guard), 32'd2);
    check("second_rdata", rsp_rdata, 32'h00001234);
    @(posedge clk);

    // reset during the READ of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h100;
    req_wdata = 32'h55;
    @(posedge clk);
    start_we = we_cnt;
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rstmid_req_ready", 32'(req_ready), 32'd1);
    end
    check("rstmid_no_write", 32'(we_cnt - start_we), 32'd0);
    run_check("rstmid_ld", 0, 2, 0, 32'h100, 32'h0, 32'h12347F01, 0, 2, 0);

    // address above the RAM range
    run_check("st_w_0", 1, 2, 0, 32'h0, 32'hCAFEF00D, 32'h0, 0, 2, 1);
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    run_check("ld_oob", 0, 2, 0, 32'h00020000, 32'h0, 32'h0, 1, 1, 0);
`else
    run_check("ld_wrap", 0, 2, 0, 32'h00020000, 32'h0, 32'hCAFEF00D, 0, 2, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
